// File: rtl/pc_fetch_ctrl.sv
// PC fetch sequencer: one outstanding imem fetch, 3-cycle zero-wait turnaround, valid/ready to decode.
// Decode backpressure holds DELIVER without refetching; trap/redirect flush any in-flight fetch.
module pc_fetch_ctrl #(
  parameter int            N           = 32,
  parameter logic [N-1:0]  RESET_PC    = 32'h0040_0000,
  parameter logic [N-1:0]  TRAP_VECTOR = 32'h0040_0180
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [31:0]   imem_rdata,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [N-1:0]  instr_pc,
  input  logic          instr_ready,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_target,
  input  logic          trap,
  output logic          misalign_err
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, DELIVER, FLUSH} state_t;

  localparam logic [N-1:0] PC_STEP = N'(4);

  state_t        state, state_nxt;
  logic [N-1:0]  pc, pc_nxt, target;
  logic          redirect_evt, target_misaligned, capture;

  always_comb begin
    redirect_evt      = trap | redirect_valid;
    target_misaligned = (redirect_target[1:0] != 2'b00);
    target            = redirect_target;
    if (trap || target_misaligned) begin
      target = TRAP_VECTOR;
    end

    state_nxt = state;
    capture   = 1'b0;
    case (state)
      BOOT:    state_nxt = REQ;
      REQ: begin
        // A granted fetch that coincides with a redirect is still in flight and must be drained.
        if (imem_gnt) begin
          state_nxt = redirect_evt ? FLUSH : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect_evt) begin
            state_nxt = REQ;
          end else begin
            state_nxt = DELIVER;
            capture   = 1'b1;
          end
        end else if (redirect_evt) begin
          state_nxt = FLUSH;
        end
      end
      DELIVER: begin
        if (instr_ready || redirect_evt) begin
          state_nxt = REQ;
        end
      end
      FLUSH: begin
        if (imem_rvalid) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase

    pc_nxt = pc;
    if (redirect_evt) begin
      pc_nxt = target;
    end else if (capture) begin
      pc_nxt = pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      instr        <= 32'h0;
      instr_pc     <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      misalign_err <= redirect_valid & ~trap & target_misaligned;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

  assign imem_req    = (state == REQ);
  assign instr_valid = (state == DELIVER);
  assign imem_addr   = pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus random traffic against a transaction-level model
// (pc, outstanding fetch, pending delivery) driven by a variable-latency memory responder.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] TV       = 32'h0040_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect_valid, trap, misalign_err;
  logic [31:0] redirect_target;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.N(32), .RESET_PC(RESET_PC), .TRAP_VECTOR(TV)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .trap(trap),
    .misalign_err(misalign_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: next fetch address, whether the outstanding fetch will still be delivered,
  // and the instruction currently owed to decode.
  logic [31:0] m_pc, m_dlv_instr, m_dlv_pc, mem_addr;
  bit          m_dlv, m_boot, m_mis, m_live, mem_busy, const_data;
  int          mem_cnt;
  int          p_gnt, dly_lo, dly_hi, p_rdy, p_ev;
  logic [31:0] grant_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return const_data ? 32'h0000_0013 : ({a[15:0], a[31:16]} ^ 32'hC3A5_5A3C);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_dlv = 0; m_boot = 1; m_mis = 0; m_live = 0;
    mem_busy = 0; mem_cnt = 0; mem_addr = 32'h0;
    grant_q.delete();
  endtask

  task automatic drive_idle();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 32'h0; instr_ready = 0;
    redirect_valid = 0; redirect_target = 32'h0; trap = 0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_imem_req", 32'(imem_req), 32'd0);
    check_eq("rst_imem_addr", imem_addr, RESET_PC);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);
  endtask

  // Called just after a falling edge: check settled outputs, drive inputs, advance model one clock.
  task automatic step(input bit f_trap, input bit f_rv, input logic [31:0] f_tgt);
    bit          rv_now, g_now, ev, nd;
    logic [31:0] tgt;
    int          k;
    check_eq("instr_valid", 32'(instr_valid), 32'(m_dlv));
    if (m_dlv) begin
      check_eq("instr", instr, m_dlv_instr);
      check_eq("instr_pc", instr_pc, m_dlv_pc);
    end
    check_eq("imem_req", 32'(imem_req), 32'(!m_boot && !mem_busy && !m_dlv));
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("misalign_err", 32'(misalign_err), 32'(m_mis));

    trap = f_trap; redirect_valid = f_rv; redirect_target = f_tgt;
    if (!f_trap && !f_rv && $urandom_range(0, 99) < p_ev) begin
      k = $urandom_range(0, 9);
      trap = (k < 3);
      redirect_valid = (k >= 2);
      case ($urandom_range(0, 3))
        0:       redirect_target = 32'hFFFF_FFFC;
        1:       redirect_target = RESET_PC + {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        default: redirect_target = RESET_PC + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
    end
    rv_now      = mem_busy && (mem_cnt == 0);
    imem_rvalid = rv_now;
    imem_rdata  = rv_now ? mem_word(mem_addr) : $urandom();
    g_now       = imem_req && ($urandom_range(0, 99) < p_gnt);
    imem_gnt    = g_now;
    instr_ready = ($urandom_range(0, 99) < p_rdy);

    ev  = trap || redirect_valid;
    tgt = (trap || redirect_target[1:0] != 2'b00) ? TV : redirect_target;
    nd  = m_dlv && !instr_ready;
    if (rv_now) begin
      if (m_live) begin
        nd = 1; m_dlv_instr = imem_rdata; m_dlv_pc = mem_addr; m_pc = mem_addr + 32'd4;
      end
      mem_busy = 0; m_live = 0;
    end else if (mem_busy) begin
      mem_cnt--;
    end
    if (g_now) begin
      mem_busy = 1; mem_cnt = $urandom_range(dly_lo, dly_hi);
      mem_addr = imem_addr; m_live = 1; grant_q.push_back(imem_addr);
    end
    if (ev) begin
      m_pc = tgt; m_live = 0; nd = 0;
    end
    m_dlv  = nd;
    m_mis  = redirect_valid && !trap && (redirect_target[1:0] != 2'b00);
    m_boot = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_req();
    int n = 0;
    while (!imem_req && n < 60) begin step(0, 0, 32'h0); n++; end
    check_eq("wait_req_bound", 32'(imem_req), 32'd1);
  endtask

  task automatic run_until_valid();
    int n = 0;
    while (!instr_valid && n < 60) begin step(0, 0, 32'h0); n++; end
    check_eq("wait_valid_bound", 32'(instr_valid), 32'd1);
  endtask

  initial begin
    int cyc;
    int vq[$];
    reset = 1'b1;
    drive_idle();
    p_gnt = 100; dly_lo = 0; dly_hi = 0; p_rdy = 100; p_ev = 0; const_data = 1;
    model_reset();
    #1 reset = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Zero-wait memory, decode always ready
    cyc = 0;
    while (!instr_valid && cyc < 20) begin step(0, 0, 32'h0); cyc++; end
    check_eq("first_valid_cycle", cyc, 32'd3);
    vq.push_back(cyc);
    while (grant_q.size() < 3 && cyc < 40) begin
      step(0, 0, 32'h0); cyc++;
      if (instr_valid) vq.push_back(cyc);
    end
    check_eq("throughput", (vq.size() >= 2) ? 32'(vq[1] - vq[0]) : 32'd0, 32'd3);
    check_eq("fetch_addr0", grant_q[0], 32'h0040_0000);
    check_eq("fetch_addr1", grant_q[1], 32'h0040_0004);
    check_eq("fetch_addr2", grant_q[2], 32'h0040_0008);
    const_data = 0;

    // Decode backpressure
    p_rdy = 0;
    run_until_valid();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h0);
      check_eq("bp_valid", 32'(instr_valid), 32'd1);
      check_eq("bp_req", 32'(imem_req), 32'd0);
      check_eq("bp_pc_hold", imem_addr, m_dlv_pc + 32'd4);
    end
    p_rdy = 100;
    step(0, 0, 32'h0);
    check_eq("bp_release_req", 32'(imem_req), 32'd1);

    // Redirect while waiting, response two cycles later
    dly_lo = 2; dly_hi = 2;
    run_until_req();
    step(0, 0, 32'h0);
    step(0, 1, 32'h0040_0040);
    check_eq("flush_no_req", 32'(imem_req), 32'd0);
    run_until_req();
    check_eq("redirect_addr", imem_addr, 32'h0040_0040);

    // Trap and redirect together while delivering
    dly_lo = 0; dly_hi = 0; p_rdy = 0;
    run_until_valid();
    step(1, 1, 32'h0040_0080);
    check_eq("trap_drop_valid", 32'(instr_valid), 32'd0);
    run_until_req();
    check_eq("trap_addr", imem_addr, TV);

    // Misaligned redirect
    p_rdy = 100;
    step(0, 1, 32'h0040_0042);
    check_eq("misalign_pulse", 32'(misalign_err), 32'd1);
    step(0, 0, 32'h0);
    check_eq("misalign_clear", 32'(misalign_err), 32'd0);
    run_until_req();
    check_eq("misalign_addr", imem_addr, TV);

    // PC wrap, then asynchronous reset in the middle of a fetch
    step(0, 1, 32'hFFFF_FFFC);
    run_until_req();
    check_eq("wrap_start_addr", imem_addr, 32'hFFFF_FFFC);
    run_until_valid();
    check_eq("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    run_until_req();
    check_eq("wrap_addr", imem_addr, 32'h0);
    dly_lo = 2; dly_hi = 2;
    step(0, 0, 32'h0);
    #2 reset = 1'b0;
    drive_idle();
    #1 check_reset_outputs();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    run_until_req();
    check_eq("restart_addr", imem_addr, RESET_PC);

    // Random traffic
    p_gnt = 70; dly_lo = 0; dly_hi = 3; p_rdy = 60; p_ev = 6;
    for (int i = 0; i < 3000; i++) step(0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer that owns the program counter and drives instruction memory for the single-issue core. It issues one word fetch at a time and hands each instruction, with its address, to decode through a valid/ready handshake. It also applies branch/jump redirects and trap entry, flushing any in-flight fetch. It sits between the `pc` register stage, instruction memory and decode, and replaces the free-running `pc_in` feed.

## Interface
- `N`, 32, address/PC width
- `RESET_PC`, 32'h0040_0000, PC value on reset
- `TRAP_VECTOR`, 32'h0040_0180, PC loaded on trap or misaligned redirect

- `clk`  in  1  clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `imem_req`  out  1  fetch request
- `imem_addr`  out  N  fetch address (= current PC)
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response data valid
- `imem_rdata`  in  32  fetched instruction word
- `instr_valid`  out  1  instruction available to decode
- `instr`  out  32  instruction word
- `instr_pc`  out  N  address of `instr`
- `instr_ready`  in  1  decode accepts instruction
- `redirect_valid`  in  1  one-cycle branch/jump redirect
- `redirect_target`  in  N  redirect address
- `trap`  in  1  one-cycle trap request
- `misalign_err`  out  1  one-cycle pulse: redirect target not word-aligned

## Operation
- States: BOOT, REQ, WAIT, DELIVER, FLUSH. Registered state; `imem_req` = (state==REQ); `instr_valid` = (state==DELIVER); `imem_addr` = pc.
- BOOT: no request; next cycle → REQ.
- REQ: hold `imem_req`=1. On `imem_gnt` → WAIT. Until granted, the address may change (redirect).
- WAIT: `imem_req`=0. On `imem_rvalid`: capture `instr`←rdata, `instr_pc`←pc, pc←pc+4, → DELIVER.
- DELIVER: outputs stable until `instr_ready`; on ready → REQ.
- FLUSH: `imem_req`=0; wait for outstanding `imem_rvalid`, discard data, → REQ.
- Redirect event priority: trap > redirect_valid. Effective target = TRAP_VECTOR if `trap`; else TRAP_VECTOR if `redirect_target[1:0]`≠0 (and `misalign_err`=1 next cycle); else `redirect_target`. pc←target.
- State on redirect event: BOOT→REQ; REQ without gnt→REQ; REQ with gnt→FLUSH; WAIT without rvalid→FLUSH; WAIT with rvalid→REQ (data dropped, pc+4 suppressed); DELIVER→REQ (instruction dropped, even if `instr_ready` same cycle); FLUSH without rvalid→FLUSH; FLUSH with rvalid→REQ.
- Arithmetic: pc+4 modulo 2^N; 32'hFFFF_FFFC wraps to 0. Redirect never adds 4.
- At most one outstanding fetch ever.

## Timing
- Reset (`reset`=0, asynchronous): state=BOOT, pc=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0, `misalign_err`=0. Reset mid-fetch abandons it; imem shares the same reset, so no late response arrives.
- Zero-wait memory (gnt in REQ, rvalid next cycle): first `instr_valid` 3 cycles after reset release (BOOT, REQ, WAIT, DELIVER); with immediate `instr_ready`, throughput 1 instruction / 3 cycles.
- Redirect takes effect on the following edge: `imem_addr`=target in next REQ cycle.
- `misalign_err` registered, high exactly one cycle after the offending redirect.
- `instr`/`instr_pc` hold their value outside DELIVER; only `instr_valid` qualifies them.

## Test plan
- Reset release, gnt immediate, rvalid 1 cycle later, rdata=32'h0000_0013, ready=1 -> addresses 0x00400000, 0x00400004, 0x00400008 issued; `instr_pc` matches; instr_valid first at cycle 3.
- Decode backpressure: `instr_ready`=0 for 4 cycles in DELIVER -> `instr`/`instr_pc` stable, `imem_req`=0, no pc advance; ready → REQ next cycle.
- Redirect to 0x00400040 in WAIT, rvalid 2 cycles later -> FLUSH, response discarded, next `imem_addr`=0x00400040, no `instr_valid` for discarded word.
- Trap and redirect(0x00400080) same cycle in DELIVER -> instruction dropped, next fetch at 0x00400180.
- Redirect to 0x00400042 -> `misalign_err` one-cycle pulse, next fetch at 0x00400180.
- Set pc via redirect to 0xFFFF_FFFC, complete one fetch -> next `imem_addr`=0x00000000; `reset`=0 asserted mid-WAIT -> all outputs at reset values immediately, restart at 0x00400000.
